// File: rtl/dram_simm_ctrl.sv
// Single-bank FPM DRAM SIMM controller: power-up wait, CBR init refreshes,
// periodic CBR refresh and fixed-latency byte read/write with registered strobes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// INIT_WAIT | power-up wait, strobes high, busy
// INIT_REF  | dispatch the next init refresh or finish init
// IDLE      | ready; refresh has priority over a request
// ROW       | one address-setup cycle, then RAS low for T_RCD cycles
// COL       | CAS low for T_CAS cycles; write drives DQ, read captures
// PRE       | precharge, all strobes high for T_RP cycles
// REF_CAS   | CBR: CAS low one cycle ahead of RAS
// REF_RAS   | CBR: RAS and CAS low for T_RAS cycles
// REF_PRE   | CBR precharge for T_RP cycles
module dram_simm_ctrl #(
    parameter int T_INIT_CYC = 10000,
    parameter int INIT_REFS  = 8,
    parameter int REF_CYC    = 750,
    parameter int T_RCD      = 2,
    parameter int T_CAS      = 2,
    parameter int T_RAS      = 4,
    parameter int T_RP       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        ena,
    input  logic        write,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        ack,
    output logic [11:0] ram_addr,
    output logic        ram_ras_,
    output logic        ram_cas_,
    output logic        ram_we_,
    output logic        dq_oe,
    output logic [7:0]  dq_out,
    input  logic [7:0]  dq_in
);

    localparam int MAX_A   = (T_INIT_CYC > T_RCD) ? T_INIT_CYC : T_RCD;
    localparam int MAX_B   = (T_CAS > T_RAS) ? T_CAS : T_RAS;
    localparam int MAX_C   = (MAX_B > T_RP) ? MAX_B : T_RP;
    localparam int TMR_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int REFC_W  = $clog2(REF_CYC + 1);
    localparam int INIT_W  = $clog2(INIT_REFS + 2);

    localparam logic [TMR_W-1:0]  TMR_INIT = TMR_W'(T_INIT_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_RCD  = TMR_W'(T_RCD);
    localparam logic [TMR_W-1:0]  TMR_CAS  = TMR_W'(T_CAS - 1);
    localparam logic [TMR_W-1:0]  TMR_RAS  = TMR_W'(T_RAS - 1);
    localparam logic [TMR_W-1:0]  TMR_RP   = TMR_W'(T_RP - 1);
    localparam logic [REFC_W-1:0] REF_LAST = REFC_W'(REF_CYC - 1);
    localparam logic [INIT_W-1:0] INIT_END = INIT_W'(INIT_REFS);

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_REF,
        IDLE,
        ROW,
        COL,
        PRE,
        REF_CAS,
        REF_RAS,
        REF_PRE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [REFC_W-1:0]   refc_q, refc_d;
    logic                ref_pend_q, ref_pend_d;
    logic                init_q, init_d;
    logic [INIT_W-1:0]   inits_q, inits_d;
    logic [7:0]          col_q, col_d;
    logic                wr_q, wr_d;
    logic [7:0]          dq_out_q, dq_out_d;
    logic [7:0]          rd_q, rd_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [11:0]         ram_addr_q, ram_addr_d;
    logic                ras_q, ras_d;
    logic                cas_q, cas_d;
    logic                we_q, we_d;
    logic                oe_q, oe_d;
    logic                accept;
    logic                tmr_zero;

    assign tmr_zero = (tmr_q == '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        init_d  = init_q;
        inits_d = inits_q;
        accept  = 1'b0;
        case (state_q)
            INIT_WAIT: begin
                if (tmr_zero) state_d = INIT_REF;
                else          tmr_d   = tmr_q - 1'b1;
            end
            INIT_REF: begin
                tmr_d = '0;
                if (inits_q == INIT_END) begin
                    state_d = IDLE;
                    init_d  = 1'b0;
                end else begin
                    state_d = REF_CAS;
                    inits_d = inits_q + 1'b1;
                end
            end
            IDLE: begin
                if (ref_pend_q) begin
                    state_d = REF_CAS;
                    tmr_d   = '0;
                end else if (ena) begin
                    state_d = ROW;
                    tmr_d   = TMR_RCD;
                    accept  = 1'b1;
                end
            end
            ROW: begin
                if (tmr_zero) begin
                    state_d = COL;
                    tmr_d   = TMR_CAS;
                end else tmr_d = tmr_q - 1'b1;
            end
            COL: begin
                if (tmr_zero) begin
                    state_d = PRE;
                    tmr_d   = TMR_RP;
                end else tmr_d = tmr_q - 1'b1;
            end
            PRE: begin
                if (tmr_zero) state_d = IDLE;
                else          tmr_d   = tmr_q - 1'b1;
            end
            REF_CAS: begin
                state_d = REF_RAS;
                tmr_d   = TMR_RAS;
            end
            REF_RAS: begin
                if (tmr_zero) begin
                    state_d = REF_PRE;
                    tmr_d   = TMR_RP;
                end else tmr_d = tmr_q - 1'b1;
            end
            REF_PRE: begin
                if (tmr_zero) state_d = init_q ? INIT_REF : IDLE;
                else          tmr_d   = tmr_q - 1'b1;
            end
            default: begin
                state_d = INIT_WAIT;
                tmr_d   = TMR_INIT;
            end
        endcase
    end

    // Interval counter is frozen at zero during init; a wrap re-arms even on the entry cycle.
    always_comb begin
        refc_d     = refc_q;
        ref_pend_d = ref_pend_q;
        if (state_d == REF_CAS && state_q != REF_CAS) ref_pend_d = 1'b0;
        if (!init_q) begin
            if (refc_q == REF_LAST) begin
                refc_d     = '0;
                ref_pend_d = 1'b1;
            end else begin
                refc_d = refc_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        col_d      = accept ? addr[7:0] : col_q;
        wr_d       = accept ? write : wr_q;
        dq_out_d   = accept ? wr_data : dq_out_q;
        ack_d      = accept;
        busy_d     = (state_d != IDLE);
        ras_d      = !((state_d == ROW && tmr_d != TMR_RCD) || state_d == COL ||
                       state_d == REF_RAS);
        cas_d      = !(state_d == COL || state_d == REF_CAS || state_d == REF_RAS);
        we_d       = !(state_d == COL && wr_q);
        oe_d       = (state_d == COL) && wr_q;
        ram_addr_d = ram_addr_q;
        if (accept)              ram_addr_d = {4'h0, addr[15:8]};
        else if (state_d == COL) ram_addr_d = {4'h0, col_q};
        rd_d       = (state_q == COL && tmr_zero && !wr_q) ? dq_in : rd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT_WAIT;
            tmr_q      <= TMR_INIT;
            refc_q     <= '0;
            ref_pend_q <= 1'b0;
            init_q     <= 1'b1;
            inits_q    <= '0;
            col_q      <= '0;
            wr_q       <= 1'b0;
            dq_out_q   <= '0;
            rd_q       <= '0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
            ram_addr_q <= '0;
            ras_q      <= 1'b1;
            cas_q      <= 1'b1;
            we_q       <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            refc_q     <= refc_d;
            ref_pend_q <= ref_pend_d;
            init_q     <= init_d;
            inits_q    <= inits_d;
            col_q      <= col_d;
            wr_q       <= wr_d;
            dq_out_q   <= dq_out_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            ram_addr_q <= ram_addr_d;
            ras_q      <= ras_d;
            cas_q      <= cas_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
        end
    end

    assign rd_data  = rd_q;
    assign busy     = busy_q;
    assign ack      = ack_q;
    assign ram_addr = ram_addr_q;
    assign ram_ras_ = ras_q;
    assign ram_cas_ = cas_q;
    assign ram_we_  = we_q;
    assign dq_oe    = oe_q;
    assign dq_out   = dq_out_q;

endmodule

// File: tb/tb_dram_simm_ctrl.sv
// Directed bench for dram_simm_ctrl: init sequence, table-driven accesses,
// refresh priority, refresh spacing and reset during an access.
module tb_dram_simm_ctrl;

    localparam int T_INIT = 20;
    localparam int REFC   = 100;
    localparam int NREF   = 8;
    localparam int RCD    = 2;
    localparam int CAS    = 2;
    localparam int RP     = 4;
    localparam int ROW_END = 1 + RCD;
    localparam int COL_END = ROW_END + CAS;
    localparam int DONE    = COL_END + RP + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic        ena;
    logic        write;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        busy;
    logic        ack;
    logic [11:0] ram_addr;
    logic        ram_ras_;
    logic        ram_cas_;
    logic        ram_we_;
    logic        dq_oe;
    logic [7:0]  dq_out;
    logic [7:0]  dq_in;
    logic [7:0]  model_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The SIMM model drives its byte whenever a read column strobe is active.
    assign dq_in = (!ram_cas_ && ram_we_) ? model_byte : 8'h00;

    dram_simm_ctrl #(
        .T_INIT_CYC (T_INIT),
        .INIT_REFS  (NREF),
        .REF_CYC    (REFC),
        .T_RCD      (RCD),
        .T_CAS      (CAS),
        .T_RAS      (4),
        .T_RP       (RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .ena      (ena),
        .write    (write),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .ack      (ack),
        .ram_addr (ram_addr),
        .ram_ras_ (ram_ras_),
        .ram_cas_ (ram_cas_),
        .ram_we_  (ram_we_),
        .dq_oe    (dq_oe),
        .dq_out   (dq_out),
        .dq_in    (dq_in)
    );

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  dqv;
        logic        hold;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_refresh(output bit ok);
        int   n;
        logic pc;
        ok = 1'b0;
        n  = 0;
        pc = ram_cas_;
        while (!ok && n < 250) begin
            @(negedge clk);
            n++;
            if (pc && !ram_cas_ && ram_ras_) ok = 1'b1;
            pc = ram_cas_;
        end
    endtask

    // Entered at the negedge of the first cycle with rst_n high.
    task automatic check_init(input string tag);
        int   bad, order_bad, cbr, n, lastf;
        logic pr, pc;
        bad = 0;
        for (int i = 0; i < T_INIT; i++) begin
            if (!busy || !ram_ras_ || !ram_cas_ || !ram_we_ || dq_oe || ack) bad++;
            @(negedge clk);
        end
        chk({tag, "_wait_quiet"}, bad, 0);
        cbr = 0; order_bad = 0; n = 0; lastf = -10;
        pr = ram_ras_; pc = ram_cas_;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
            if (pc && !ram_cas_) begin
                if (ram_ras_) begin
                    cbr++;
                    lastf = n;
                end else order_bad++;
            end
            if (pr && !ram_ras_ && (n - lastf != 1 || ram_cas_)) order_bad++;
            if (ack || !ram_we_ || dq_oe) order_bad++;
            pr = ram_ras_; pc = ram_cas_;
        end
        chk({tag, "_busy_released"}, busy, 0);
        chk({tag, "_cbr_count"}, cbr, NREF);
        chk({tag, "_cbr_order"}, order_bad, 0);
    endtask

    task automatic do_access(input vec_t v, input int idx);
        int         n;
        logic [5:0] e;
        logic       in_row, in_col;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_idle_before", idx), busy, 0);
        addr = v.a; write = v.wr; wr_data = v.wd; model_byte = v.dqv; ena = 1'b1;
        for (int c = 1; c <= DONE; c++) begin
            @(negedge clk);
            in_row = (c >= 2 && c <= ROW_END);
            in_col = (c > ROW_END && c <= COL_END);
            e = {c == 1, c < DONE, !(in_row || in_col), !in_col, !(in_col && v.wr), in_col && v.wr};
            chk($sformatf("v%0d_c%0d_ack_busy_ras_cas_we_oe", idx, c),
                {ack, busy, ram_ras_, ram_cas_, ram_we_, dq_oe}, e);
            if (c <= ROW_END)
                chk($sformatf("v%0d_c%0d_row_addr", idx, c), ram_addr, {4'h0, v.a[15:8]});
            else if (in_col)
                chk($sformatf("v%0d_c%0d_col_addr", idx, c), ram_addr, {4'h0, v.a[7:0]});
            if (in_col && v.wr)
                chk($sformatf("v%0d_c%0d_dq_out", idx, c), dq_out, v.wd);
            if (c == DONE)
                chk($sformatf("v%0d_rd_data", idx), rd_data, v.exp_rd);
            if (c == 1) begin
                addr = ~v.a; wr_data = ~v.wd; write = ~v.wr;
                if (!v.hold) ena = 1'b0;
            end
            if (c == DONE - 1) ena = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   acks, ack_n, ref_n, cnt, bad, last;
        logic pc;

        vecs[0] = '{1'b1, 16'h12AB, 8'h5A, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 16'h12AB, 8'h00, 8'h5A, 1'b0, 8'h5A};
        vecs[2] = '{1'b1, 16'h0000, 8'hFF, 8'h00, 1'b0, 8'h5A};
        vecs[3] = '{1'b0, 16'hFF01, 8'h00, 8'hC3, 1'b1, 8'hC3};
        vecs[4] = '{1'b1, 16'h8000, 8'h01, 8'h00, 1'b1, 8'hC3};
        vecs[5] = '{1'b0, 16'h00FF, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 16'h7E7E, 8'h00, 8'hA5, 1'b0, 8'hA5};

        rst_n = 1'b0; ena = 1'b0; write = 1'b0; addr = '0; wr_data = '0; model_byte = '0;
        repeat (4) @(negedge clk);
        chk("reset_ack_busy_ras_cas_we_oe", {ack, busy, ram_ras_, ram_cas_, ram_we_, dq_oe}, 6'b011110);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_ram_addr", ram_addr, 0);
        rst_n = 1'b1;
        check_init("init1");

        for (int i = 0; i < 7; i++) begin
            wait_refresh(ok);
            chk($sformatf("v%0d_sync_refresh", i), ok, 1);
            do_access(vecs[i], i);
        end

        // Request raised in the cycle the refresh becomes pending.
        wait_refresh(ok);
        chk("pend_sync_refresh", ok, 1);
        repeat (REFC - 1) @(negedge clk);
        addr = 16'h3C4D; write = 1'b0; model_byte = 8'h96; ena = 1'b1;
        acks = 0; ack_n = -1; ref_n = -1; pc = ram_cas_;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (pc && !ram_cas_ && ram_ras_ && ref_n < 0) ref_n = n;
            if (ack) begin
                acks++;
                if (ack_n < 0) ack_n = n;
                ena = 1'b0;
            end
            pc = ram_cas_;
        end
        ena = 1'b0;
        chk("pend_refresh_before_ack", (ref_n >= 1) && (ack_n > ref_n + 8), 1);
        chk("pend_single_ack", acks, 1);
        chk("pend_read_data", rd_data, 8'h96);

        cnt = 0; bad = 0; last = -1; pc = ram_cas_;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (pc && !ram_cas_ && ram_ras_) begin
                if (last >= 0 && n - last != REFC) bad++;
                last = n;
                cnt++;
            end
            if (ack) bad++;
            pc = ram_cas_;
        end
        chk("idle_refresh_count", cnt, 10);
        chk("idle_refresh_spacing", bad, 0);

        // Reset during the column phase of a write.
        wait_refresh(ok);
        chk("rst_sync_refresh", ok, 1);
        repeat (9) @(negedge clk);
        addr = 16'h5555; write = 1'b1; wr_data = 8'h11; ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        cnt = 0;
        while (ram_cas_ && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_reached_col_write", {ram_cas_, ram_we_, dq_oe}, 3'b001);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ack_busy_ras_cas_we_oe", {ack, busy, ram_ras_, ram_cas_, ram_we_, dq_oe}, 6'b011110);
        chk("rst_rd_data_cleared", rd_data, 0);
        chk("rst_ram_addr_cleared", ram_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_init("init2");
        do_access(vecs[1], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
